// File: rtl/regfile_wb_if.sv
// Writeback bus between the NUM_REQ writeback sources and the register-file
// write port arbiter.
//   req_valid / req_ready : per-source valid/ready handshake
//   req_reg / req_data    : packed per-source destination and data,
//                           source i in slice [i*W +: W]
//   req_float             : per-source FP-file select
//   wb_hold               : 1 = write port reserved, no grants this cycle
//   writeReg / writeData / regWrite / float : registered write command to the register file
//   starve                : per-source wait watchdog status
// Modports: master = writeback sources / register file side, slave = arbiter.
interface regfile_wb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_float;
    logic                      wb_hold;
    logic [ADDR_W-1:0]         writeReg;
    logic [DATA_W-1:0]         writeData;
    logic                      regWrite;
    logic                      float;
    logic [NUM_REQ-1:0]        starve;

    modport master (
        output req_valid, req_reg, req_data, req_float, wb_hold,
        input  req_ready, writeReg, writeData, regWrite, float, starve
    );

    modport slave (
        input  req_valid, req_reg, req_data, req_float, wb_hold,
        output req_ready, writeReg, writeData, regWrite, float, starve
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NUM_REQ writeback sources (ALU, load, mul/div, FP).
// Ports:
//   clk  : single clock, rising-edge state updates
//   rst  : asynchronous, active-high reset
//   bus  : regfile_wb_if.slave -- per-source valid/ready/payload, wb_hold,
//          registered write command (writeReg/writeData/regWrite/float)
//          and per-source starve watchdog flags.
// A grant is combinational (req_ready); the write command appears on the
// register outputs one cycle after the transfer.
module regfile_wb_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    regfile_wb_if.slave   bus
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  scanIdx;
    logic [PTR_W-1:0]  grantIdx;
    logic              grantAny;
    logic [NUM_REQ-1:0] grantVec;

    logic [ADDR_W-1:0] selReg;
    logic [DATA_W-1:0] selData;
    logic              selFloat;

    logic [CNT_W-1:0]  waitCnt  [NUM_REQ];
    logic [CNT_W-1:0]  waitNext [NUM_REQ];

    // (base + offs) mod NUM_REQ; both operands are below NUM_REQ so a
    // single conditional subtract is enough.
    function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PTR_W'(s);
    endfunction

    // Grant: first valid source scanning from rrPtr; nothing during reset or hold.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        scanIdx  = '0;
        if (!rst && !bus.wb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scanIdx = wrapAdd(rrPtr, k);
                if (!grantAny && bus.req_valid[scanIdx]) begin
                    grantAny = 1'b1;
                    grantIdx = scanIdx;
                end
            end
        end
        grantVec = grantAny ? (NUM_REQ'(1) << grantIdx) : '0;
    end

    assign bus.req_ready = grantVec;

    // Payload of the granted source.
    always_comb begin
        selReg   = bus.req_reg[grantIdx*ADDR_W +: ADDR_W];
        selData  = bus.req_data[grantIdx*DATA_W +: DATA_W];
        selFloat = bus.req_float[grantIdx];
    end

    // Round-robin pointer: moves past the winner only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr <= '0;
        end else if (grantAny) begin
            rrPtr <= wrapAdd(grantIdx, 1);
        end
    end

    // Output stage: one registered write command per cycle.
    // An integer write to $zero is consumed but never pulses regWrite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.writeReg  <= '0;
            bus.writeData <= '0;
            bus.float     <= 1'b0;
            bus.regWrite  <= 1'b0;
        end else begin
            bus.regWrite <= grantAny && ((selReg != '0) || selFloat);
            if (grantAny) begin
                bus.writeReg  <= selReg;
                bus.writeData <= selData;
                bus.float     <= selFloat;
            end
        end
    end

    // Watchdog: count cycles a source is valid but not granted, saturating.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            waitNext[i] = '0;
            if (bus.req_valid[i] && !grantVec[i]) begin
                waitNext[i] = (waitCnt[i] == WAIT_MAX) ? WAIT_MAX : waitCnt[i] + 1'b1;
            end
        end
    end

    // starve is registered from the same next-state value, so it always
    // equals (waitCnt == MAX_WAIT) without a combinational compare on the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                waitCnt[i] <= '0;
            end
            bus.starve <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                waitCnt[i]    <= waitNext[i];
                bus.starve[i] <= (waitNext[i] == WAIT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue/array reference model of the
// round-robin writeback rules.
module tb_regfile_wb_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_wb_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Source-side stimulus state
    logic          pend   [NR];
    logic [AW-1:0] pReg   [NR];
    logic [DW-1:0] pData  [NR];
    logic          pFloat [NR];
    logic          hold;

    // Reference model
    int            mPtr;
    int            mWait [NR];
    logic [AW-1:0] mReg;
    logic [DW-1:0] mData;
    logic          mFloat;
    logic          mWrite;
    logic [NR-1:0] mStarve;
    int            lastGrant;
    int            grantLog[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = pend[i];
            bus.req_reg[i*AW +: AW]   = pReg[i];
            bus.req_data[i*DW +: DW]  = pData[i];
            bus.req_float[i]          = pFloat[i];
        end
        bus.wb_hold = hold;
    endtask

    task automatic modelReset();
        mPtr = 0;
        for (int i = 0; i < NR; i++) mWait[i] = 0;
        mReg = '0; mData = '0; mFloat = 1'b0; mWrite = 1'b0; mStarve = '0;
    endtask

    function automatic int expGrant();
        if (rst || hold) return -1;
        for (int k = 0; k < NR; k++) begin
            if (pend[(mPtr + k) % NR]) return (mPtr + k) % NR;
        end
        return -1;
    endfunction

    function automatic void newReq(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d, input logic f);
        pend[i] = 1'b1; pReg[i] = r; pData[i] = d; pFloat[i] = f;
    endfunction

    // One clock cycle: entered just after a rising edge with stimulus set;
    // checks the combinational grant, then the registered outputs after the edge.
    task automatic cycle();
        int g;
        logic [NR-1:0] expReady;
        drive();
        #2;
        g = expGrant();
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        check("req_ready", bus.req_ready, expReady);
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] || i == g) mWait[i] = 0;
                else if (mWait[i] < MW) mWait[i]++;
                mStarve[i] = (mWait[i] == MW);
            end
            if (g >= 0) begin
                mReg = pReg[g]; mData = pData[g]; mFloat = pFloat[g];
                mWrite = (pReg[g] != 0) || pFloat[g];
                mPtr = (g + 1) % NR;
                grantLog.push_back(g);
            end else begin
                mWrite = 1'b0;
            end
        end
        lastGrant = g;
        if (g >= 0) pend[g] = 1'b0;
        #1;
        check("regWrite",  bus.regWrite,  mWrite);
        check("writeReg",  bus.writeReg,  mReg);
        check("writeData", bus.writeData, mData);
        check("float",     bus.float,     mFloat);
        check("starve",    bus.starve,    mStarve);
    endtask

    initial begin
        int logStart;

        // 1: reset with every source valid
        rst = 1'b1;
        hold = 1'b0;
        for (int i = 0; i < NR; i++) newReq(i, AW'(i + 1), $urandom, 1'b0);
        modelReset();
        cycle();
        cycle();
        check("reset_ready", bus.req_ready, 0);
        rst = 1'b0;
        cycle();
        check("first_grant", lastGrant, 0);
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        cycle();

        // 2: single write from source 2
        newReq(2, 5'd5, 32'hDEADBEEF, 1'b0);
        cycle();
        check("single_grant", lastGrant, 2);
        check("single_reg",   bus.writeReg, 5);
        check("single_data",  bus.writeData, 32'hDEADBEEF);
        check("single_we",    bus.regWrite, 1);
        cycle();
        check("single_pulse_end", bus.regWrite, 0);

        // 3: all sources valid continuously
        logStart = grantLog.size();
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i]) newReq(i, AW'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)));
            cycle();
            check("b2b_pulse", bus.regWrite, 1);
        end
        for (int k = logStart + 1; k < grantLog.size(); k++)
            check("rr_order", grantLog[k], (grantLog[k-1] + 1) % NR);
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        cycle();

        // 4: writes to register 0
        newReq(1, 5'd0, 32'h1234_5678, 1'b0);
        cycle();
        check("zero_grant", lastGrant, 1);
        check("zero_we",    bus.regWrite, 0);
        newReq(1, 5'd0, 32'h0BAD_F00D, 1'b1);
        cycle();
        check("fzero_we",    bus.regWrite, 1);
        check("fzero_float", bus.float, 1);
        check("fzero_reg",   bus.writeReg, 0);

        // 5: hold with source 3 waiting
        newReq(3, 5'd9, 32'hCAFE_0003, 1'b0);
        hold = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check("hold_starve3", bus.starve[3], (c >= MW - 1) ? 1 : 0);
        end
        hold = 1'b0;
        cycle();
        check("hold_release_grant", lastGrant, 3);
        check("starve3_clear", bus.starve[3], 0);

        // 6: asynchronous reset in the middle of a burst
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i]) newReq(i, AW'($urandom_range(1, 31)), $urandom, 1'b0);
            cycle();
        end
        check("burst_pulse", bus.regWrite, 1);
        rst = 1'b1;
        #1;
        check("async_rst_we",  bus.regWrite, 0);
        check("async_rst_reg", bus.writeReg, 0);
        modelReset();
        cycle();
        for (int i = 0; i < NR; i++)
            if (!pend[i]) newReq(i, AW'($urandom_range(1, 31)), $urandom, 1'b0);
        rst = 1'b0;
        cycle();
        check("post_rst_grant", lastGrant, 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            hold = ($urandom_range(0, 99) < 15);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    newReq(i, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, 31)),
                           $urandom, 1'($urandom_range(0, 1)));
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
